// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU/host arbiter for one single-port memory; define MEM_ARB_RR_EN for round-robin ties (default: host always wins ties)
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_gnt,
  output logic              host_gnt,
  output logic              cpu_rvalid,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              cpu_stall
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            r_state, w_next;
  logic              r_we, r_win_host;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_any, w_decide, w_take, w_pick_host;
  assign w_any    = cpu_req | host_req;
  assign w_decide = (r_state == IDLE) | (r_state == RESP) | ((r_state == ACCESS) & r_we);
  assign w_take   = w_decide & w_any;
`ifdef MEM_ARB_RR_EN
  logic r_last_host;
  assign w_pick_host = host_req & (~cpu_req | ~r_last_host);
  // remember who won the last arbitration so the next tie goes to the other side
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_last_host <= 1'b1;
    else if (w_take) r_last_host <= w_pick_host;
`else
  assign w_pick_host = host_req;
`endif
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  // next state: every decision point goes to ACCESS when anything is requesting; a read parks one cycle in RESP
  always_comb begin
    w_next = IDLE;
    if (w_decide) w_next = w_any ? ACCESS : IDLE;
    else if (r_state == ACCESS) w_next = RESP;
  end
  // capture the winner's access at the decision point; held untouched until the next decision
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_win_host <= 1'b0;
    end else if (w_take) begin
      r_addr     <= w_pick_host ? host_addr : cpu_addr;
      r_wdata    <= w_pick_host ? host_wdata : cpu_wdata;
      r_we       <= w_pick_host ? host_we : cpu_we;
      r_win_host <= w_pick_host;
    end
  // outputs decode straight from state so reset clears them without waiting for a clock
  always_comb begin
    mem_en      = r_state == ACCESS;
    mem_we      = mem_en & r_we;
    mem_addr    = r_addr;
    mem_wdata   = r_wdata;
    cpu_gnt     = mem_en & ~r_win_host;
    host_gnt    = mem_en & r_win_host;
    cpu_rvalid  = (r_state == RESP) & ~r_win_host;
    host_rvalid = (r_state == RESP) & r_win_host;
    rdata       = (r_state == RESP) ? mem_rdata : '0;
    cpu_stall   = reset_n & cpu_req & ~cpu_gnt;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus scoreboarded read data for mem_arbiter, with corner-case sequences
module tb_mem_arbiter;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, host_addr = '0, host_wdata = '0;
  logic [15:0] mem_rdata, mem_addr, mem_wdata, rdata;
  logic        mem_en, mem_we, cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, cpu_stall;
  logic [15:0] mem [0:255];
  int          n_chk = 0, n_err = 0, n_w30 = 0;

  typedef struct {logic host; logic [15:0] data;} sb_t;
  typedef struct {logic host; logic we; logic [15:0] addr; logic [15:0] wdata; logic [15:0] exp_rdata;} vec_t;
  sb_t  sb_q[$];
  vec_t vecs[10];

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_gnt(cpu_gnt), .host_gnt(host_gnt), .cpu_rvalid(cpu_rvalid), .host_rvalid(host_rvalid),
    .rdata(rdata), .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_addr == 16'h0030) n_w30 <= n_w30 + 1;
      end else mem_rdata <= mem[mem_addr[7:0]];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (reset_n) begin
      if (cpu_rvalid | host_rvalid) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_unexpected_rvalid: got cpu=%0b host=%0b, expected none at %0t", cpu_rvalid, host_rvalid, $time);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("sb_rvalid_src", {cpu_rvalid, host_rvalid}, e.host ? 2'b01 : 2'b10);
          chk("sb_rdata", rdata, e.data);
        end
      end
      chk("one_gnt", cpu_gnt & host_gnt, 0);
      chk("we_qualified", mem_we & ~mem_en, 0);
    end

  task automatic access(input logic host, input logic we, input logic [15:0] a, input logic [15:0] d, input logic [15:0] e);
    @(posedge clk); #1;
    if (host) begin host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; end
    else begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    @(negedge clk);
    chk("req_cycle_gnt", {cpu_gnt, host_gnt}, 0);
    chk("req_cycle_stall", cpu_stall, !host);
    @(negedge clk);
    chk("gnt", {cpu_gnt, host_gnt}, host ? 2'b01 : 2'b10);
    chk("mem_en_we", {mem_en, mem_we}, {1'b1, we});
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, d);
    chk("gnt_cycle_stall", cpu_stall, 0);
    if (!we) sb_q.push_back('{host, e});
    if (host) host_req = 1'b0; else cpu_req = 1'b0;
    if (!we) begin
      @(negedge clk);
      chk("rvalid", {cpu_rvalid, host_rvalid}, host ? 2'b01 : 2'b10);
      chk("resp_stall", cpu_stall, 0);
      chk("resp_mem_en", mem_en, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nh, nc, ng, cyc;
    logic [3:0] seq, exp_seq;
    vecs[0] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234};
    vecs[4] = '{1'b0, 1'b1, 16'h00FF, 16'hA5A5, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'hA5A5};
    vecs[6] = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[8] = '{1'b0, 1'b1, 16'h0010, 16'h0001, 16'h0000};
    vecs[9] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0001};
    cpu_req = 1'b1;
    host_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {mem_en, mem_we, cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, cpu_stall}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    chk("reset_rdata", rdata, 0);
    cpu_req = 1'b0;
    host_req = 1'b0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 10; i++)
      access(vecs[i].host, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    // reset in the middle of a CPU read's RESP cycle, CPU keeps requesting
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    chk("abort_gnt", cpu_gnt, 1);
    @(posedge clk); #2;
    chk("abort_pre_rvalid", cpu_rvalid, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_ctrl", {mem_en, mem_we, cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, cpu_stall}, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_rdata", rdata, 0);
    @(negedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    chk("regrant_gnt", {cpu_gnt, host_gnt}, 2'b10);
    chk("regrant_addr", mem_addr, 16'h0010);
    sb_q.push_back('{1'b0, 16'h0001});
    cpu_req = 1'b0;
    @(negedge clk);
    chk("regrant_rvalid", cpu_rvalid, 1);
    // both sides stream two writes each
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'hC0C0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0050; host_wdata = 16'h4040;
    @(negedge clk);
    nh = 0; nc = 0; ng = 0; cyc = 0; seq = '0;
    while (ng < 4 && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (host_gnt) begin
        seq[3-ng] = 1'b1; ng++; nh++;
        if (nh == 2) host_req = 1'b0;
      end else if (cpu_gnt) begin
        seq[3-ng] = 1'b0; ng++; nc++;
        if (nc == 2) cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    host_req = 1'b0;
`ifdef MEM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b1100;
`endif
    chk("arb_grants", ng, 4);
    chk("arb_back_to_back", cyc, 4);
    chk("arb_order", seq, exp_seq);
    @(negedge clk);
    chk("arb_idle", mem_en, 0);
    access(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hC0C0);
    access(1'b1, 1'b0, 16'h0050, 16'h0000, 16'h4040);
    // CPU pulses a request only inside a host read's ACCESS cycle
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020; host_wdata = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    chk("blip_host_gnt", {cpu_gnt, host_gnt}, 2'b01);
    sb_q.push_back('{1'b1, 16'h1234});
    host_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h7777;
    #2 cpu_req = 1'b0;
    @(negedge clk);
    chk("blip_resp", {mem_en, cpu_gnt, host_rvalid}, 3'b001);
    @(negedge clk);
    chk("blip_after", {mem_en, cpu_gnt}, 0);
    repeat (2) @(negedge clk);
    chk("blip_no_write", n_w30, 0);
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
